// File: rtl/jtag_pkg.sv
// Shared types and constants for the multi-channel JTAG TAP.
// Contents:
//   tap_state_e  - the 16 TAP controller states, 4-bit encoding
//   IR_BYPASS0, IR_IDCODE, IR_BYPASS1 - fixed opcodes, 8 bits wide;
//                  users slice them down to the IR width
//   chan_opcode() - opcode that selects external DR channel k
package jtag_pkg;

    // Encoding follows the customary 1149.1 state numbering.
    typedef enum logic [3:0] {
        TAP_EX2_DR = 4'h0,
        TAP_EX1_DR = 4'h1,
        TAP_SH_DR  = 4'h2,
        TAP_PAU_DR = 4'h3,
        TAP_SEL_IR = 4'h4,
        TAP_UPD_DR = 4'h5,
        TAP_CAP_DR = 4'h6,
        TAP_SEL_DR = 4'h7,
        TAP_EX2_IR = 4'h8,
        TAP_EX1_IR = 4'h9,
        TAP_SH_IR  = 4'hA,
        TAP_PAU_IR = 4'hB,
        TAP_RTI    = 4'hC,
        TAP_UPD_IR = 4'hD,
        TAP_CAP_IR = 4'hE,
        TAP_TLR    = 4'hF
    } tap_state_e;

    // Widest legal IR is 8 bits. The all-ones opcode is sliced to the real
    // IR width, which keeps it all-ones at any width.
    localparam logic [7:0] IR_BYPASS0 = 8'h00;
    localparam logic [7:0] IR_IDCODE  = 8'h01;
    localparam logic [7:0] IR_BYPASS1 = 8'hFF;

    function automatic logic [31:0] chan_opcode(input int unsigned base,
                                                input int unsigned k);
        return 32'(base + k);
    endfunction

endpackage

// File: rtl/flopr.sv
// Generic resettable register.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous, active-low reset; loads ResetValue
//   d     - next value
//   q     - registered value
module flopr #(
    parameter int unsigned       Width      = 1,
    parameter logic [Width-1:0]  ResetValue = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= ResetValue;
        else        q <= d;
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller state machine.
// Ports:
//   tck   - test clock
//   trst  - asynchronous, active-low test reset; forces TLR
//   tms   - test mode select
//   state - current TAP state
//
// state      | meaning
// -----------+-----------------------------------------------
// TAP_TLR    | test-logic-reset, instruction forced to IDCODE
// TAP_RTI    | run-test/idle
// TAP_SEL_DR | select-DR-scan
// TAP_CAP_DR | capture selected data register
// TAP_SH_DR  | shift selected data register
// TAP_EX1_DR | exit1-DR
// TAP_PAU_DR | pause-DR, all registers hold
// TAP_EX2_DR | exit2-DR
// TAP_UPD_DR | update-DR
// TAP_SEL_IR | select-IR-scan
// TAP_CAP_IR | capture IR
// TAP_SH_IR  | shift IR
// TAP_EX1_IR | exit1-IR
// TAP_PAU_IR | pause-IR, all registers hold
// TAP_EX2_IR | exit2-IR
// TAP_UPD_IR | update-IR, IR takes effect at the exit edge
module jtag_tap_ctrl
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) state_q <= TAP_TLR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TAP_TLR:    state_d = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    state_d = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: state_d = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: state_d = tms ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: state_d = tms ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: state_d = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: state_d = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: state_d = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: state_d = tms ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: state_d = tms ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: state_d = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: state_d = tms ? TAP_SEL_DR : TAP_RTI;
            default:    state_d = TAP_TLR;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_tap_mc.sv
// Multi-channel JTAG TAP: TAP controller, IR, IDCODE and BYPASS registers,
// NumChan external DR channels selected by opcode, and a saturating
// Run-Test/Idle cycle counter for DMI idle-wait enforcement.
// Ports:
//   tck, trst        - test clock; asynchronous active-low test reset
//   tms, tdi         - JTAG serial control and data in
//   tdo, tdo_oe      - registered serial data out and its output enable
//   chan_tdo         - serial out of each external channel
//   chan_select      - one-hot, bit k while IR holds channel k's opcode
//   test_logic_reset, run_test_idle, capture_dr, shift_dr, update_dr
//                    - state strobes, decoded from the current state
//   ir_q             - current instruction
//   idle_cnt         - consecutive cycles in Run-Test/Idle, saturating
module jtag_tap_mc
    import jtag_pkg::*;
#(
    parameter int unsigned         IrLength       = 5,
    parameter logic [31:0]         IdcodeValue    = 32'h00000001,
    parameter logic [IrLength-1:0] IrCaptureValue = {{(IrLength-1){1'b0}}, 1'b1},
    parameter int unsigned         NumChan        = 2,
    parameter int unsigned         ChanIrBase     = 'h10,
    parameter int unsigned         IdleCntW       = 4
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_oe,
    input  logic [NumChan-1:0]  chan_tdo,
    output logic [NumChan-1:0]  chan_select,
    output logic                test_logic_reset,
    output logic                run_test_idle,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic [IrLength-1:0] ir_q,
    output logic [IdleCntW-1:0] idle_cnt
);

    localparam logic [IrLength-1:0] OpBypass0 = IR_BYPASS0[IrLength-1:0];
    localparam logic [IrLength-1:0] OpIdcode  = IR_IDCODE[IrLength-1:0];
    localparam logic [IrLength-1:0] OpBypass1 = IR_BYPASS1[IrLength-1:0];

    tap_state_e          state;
    logic [IrLength-1:0] ir_sr;
    logic [31:0]         idcode_sr;
    logic                bypass_q;
    logic                tlr_next;
    logic                rti_next;
    logic                sel_idcode;
    logic                op_fixed;
    logic [NumChan-1:0]  chan_sel;
    logic                tdo_d;
    logic                tdo_oe_d;

    jtag_tap_ctrl u_ctrl (
        .tck   (tck),
        .trst  (trst),
        .tms   (tms),
        .state (state)
    );

    // TLR is only entered from TLR itself or from Select-IR-Scan, so the
    // entering edge can be spotted without a second copy of the FSM.
    assign tlr_next = tms && (state == TAP_TLR || state == TAP_SEL_IR);

    // The idle count has to read 0 in the first cycle after RTI and 1 in
    // the first RTI cycle, so it is driven by where the FSM is going.
    assign rti_next = !tms && (state inside {TAP_TLR, TAP_RTI, TAP_UPD_DR, TAP_UPD_IR});

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_sr <= '0;
            ir_q  <= OpIdcode;
        end else if (tlr_next) begin
            ir_sr <= '0;
            ir_q  <= OpIdcode;
        end else begin
            if (state == TAP_CAP_IR)     ir_sr <= IrCaptureValue;
            else if (state == TAP_SH_IR) ir_sr <= {tdi, ir_sr[IrLength-1:1]};
            if (state == TAP_UPD_IR)     ir_q  <= ir_sr;
        end
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst)                                          idcode_sr <= IdcodeValue;
        else if (state == TAP_TLR || state == TAP_CAP_DR)   idcode_sr <= IdcodeValue;
        else if (state == TAP_SH_DR)                        idcode_sr <= {tdi, idcode_sr[31:1]};
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst)                                 bypass_q <= 1'b0;
        else if (tlr_next || state == TAP_CAP_DR)  bypass_q <= 1'b0;
        else if (state == TAP_SH_DR)               bypass_q <= tdi;
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst)                 idle_cnt <= '0;
        else if (!rti_next)        idle_cnt <= '0;
        else if (idle_cnt != '1)   idle_cnt <= idle_cnt + IdleCntW'(1);
    end

    // The fixed opcodes win over a channel opcode that collides with them.
    always_comb begin
        sel_idcode = (ir_q == OpIdcode);
        op_fixed   = sel_idcode || (ir_q == OpBypass0) || (ir_q == OpBypass1);
        chan_sel   = '0;
        for (int unsigned k = 0; k < NumChan; k++) begin
            if (!op_fixed && (32'(ir_q) == chan_opcode(ChanIrBase, k)))
                chan_sel[k] = 1'b1;
        end
    end

    always_comb begin
        tdo_d = bypass_q;
        if (state == TAP_SH_IR)  tdo_d = ir_sr[0];
        else if (sel_idcode)     tdo_d = idcode_sr[0];
        else if (|chan_sel)      tdo_d = |(chan_sel & chan_tdo);
    end

    assign tdo_oe_d = (state == TAP_SH_IR) || (state == TAP_SH_DR);

    flopr #(.Width(1), .ResetValue(1'b0)) u_tdo_q (
        .clk   (tck),
        .rst_n (trst),
        .d     (tdo_d),
        .q     (tdo)
    );

    flopr #(.Width(1), .ResetValue(1'b0)) u_tdo_oe_q (
        .clk   (tck),
        .rst_n (trst),
        .d     (tdo_oe_d),
        .q     (tdo_oe)
    );

    assign chan_select      = chan_sel;
    assign test_logic_reset = (state == TAP_TLR);
    assign run_test_idle    = (state == TAP_RTI);
    assign capture_dr       = (state == TAP_CAP_DR);
    assign shift_dr         = (state == TAP_SH_DR);
    assign update_dr        = (state == TAP_UPD_DR);

endmodule

// File: doc/jtag_tap_mc.md
# jtag_tap_mc

Parametrised multi-channel IEEE 1149.1 TAP for the debug module. It contains its own 16-state TAP controller, an IR of configurable length, the IDCODE and BYPASS data registers, and `NumChan` external data-register channels, each selected by its own IR opcode. It also counts Run-Test/Idle cycles for DMI idle-wait enforcement. It sits between the JTAG pads and the DTM register logic (DTMCS, DMI, and future user channels).

## Interface
Parameters:
- `IrLength`, 5, IR width; legal range 2..8.
- `IdcodeValue`, 32'h00000001, IDCODE contents; bit 0 must be 1.
- `IrCaptureValue`, 'b00001, value loaded into the IR shift register in Capture-IR; bits [1:0] must be 2'b01.
- `NumChan`, 2, number of external DR channels; range 1..8.
- `ChanIrBase`, 'h10, opcode of channel 0; channel k uses `ChanIrBase+k`.
- `IdleCntW`, 4, width of the Run-Test/Idle counter.

Ports:
- `tck` in 1: JTAG test clock. This is the only clock; all state updates on its rising edge.
- `trst` in 1: test reset, asynchronous, active-low.
- `tms` in 1: test mode select.
- `tdi` in 1: test data in.
- `tdo` out 1: registered test data out.
- `tdo_oe` out 1: registered output enable.
- `chan_tdo` in `NumChan`: serial output of each external channel.
- `chan_select` out `NumChan`: one-hot; bit k is high while the IR holds channel k's opcode.
- `test_logic_reset`, `run_test_idle`, `capture_dr`, `shift_dr`, `update_dr` out 1 each: Moore state strobes.
- `ir_q` out `IrLength`: current instruction.
- `idle_cnt` out `IdleCntW`: consecutive cycles spent in Run-Test/Idle, saturating.

## Operation
- **FSM states:** TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR.
  - Transitions follow IEEE 1149.1 Fig. 6-1 exactly.
  - Five consecutive cycles with `tms`=1 reach TLR from any state.
- **IR shift register:**
  - In CapIR it loads `IrCaptureValue`.
  - In ShIR it shifts right, loading `tdi` into the MSB.
  - In UpdIR its contents are transferred to `ir_q`.
- **IR decode:**
  - 0 and all-ones select BYPASS.
  - 1 selects IDCODE.
  - `ChanIrBase+k`, for k < `NumChan`, asserts `chan_select[k]`.
  - Every other opcode selects BYPASS.
- **IDCODE register:** reloads `IdcodeValue` in CapDR and in TLR. In ShDR it shifts right with `tdi` entering bit 31.
- **BYPASS register:** loads 0 in CapDR. In ShDR it loads `tdi`.
- **tdo mux input:**
  - In ShIR: IR shift register bit 0.
  - Otherwise: IDCODE bit 0, `chan_tdo[k]`, or the bypass bit, according to the IR decode.
- **Registered outputs:** `tdo` registers the mux input every cycle. `tdo_oe` registers (ShIR | ShDR).
- **Idle counter:** `idle_cnt` increments each cycle the FSM is in RTI and saturates at all-ones. It clears to 0 in any other state.
- **Channel registers:** external channels do their own capture, shift and update using the strobes and `chan_select`. This block never gates `tck`.
- **Entering TLR** by any means forces `ir_q` to IDCODE, the IR shift register to 0, and the bypass bit to 0.

## Timing
- **Reset values** while `trst`=0:
  - FSM in TLR; `test_logic_reset`=1; all other strobes 0.
  - `ir_q`=IDCODE; `chan_select`=0.
  - IDCODE register = `IdcodeValue`; bypass bit = 0.
  - `tdo`=0; `tdo_oe`=0; `idle_cnt`=0.
- Reset takes effect asynchronously on the falling edge of `trst`, including in the middle of a shift; any partially shifted IR is discarded. Release is sampled at the next `tck` edge.
- **Strobes** are combinational decodes of the current state and are valid for the whole cycle.
- **Capture** happens at the edge that leaves CapDR/CapIR.
- **IR update** happens at the edge that leaves UpdIR, so `ir_q` and `chan_select` change one cycle after UpdIR is entered.
- **Serial latency:**
  - The first captured bit appears on `tdo` one cycle after entering ShDR/ShIR.
  - BYPASS presents `tdi` on `tdo` with a 2-cycle delay from the first shift cycle.
- **Simultaneous events:** when the FSM moves UpdIR→SelDR, the new IR is already in effect for the next CapDR.
- **Pause states** (PauDR/PauIR) hold all registers; `tdo_oe` drops one cycle after leaving a shift state.

## Structure
- Package `jtag_pkg` holds:
  - the `tap_state_e` enum (16 states, 4-bit encoding);
  - the opcode constants BYPASS0, IDCODE and BYPASS1;
  - a function computing the channel opcode from `ChanIrBase` and k.
- One sub-module, `jtag_tap_ctrl`, holds the FSM: inputs `tck`, `trst`, `tms`; output the current `tap_state_e`.
- IR, IDCODE, bypass, the idle counter and the output flops live in `jtag_tap_mc`, using `flopr` for the output registers.

## Test plan
- **Reset then IDCODE read** (`IdcodeValue`=32'h1002AC05): apply `trst` low, then TMS 0,1,0,0 and 32 shift cycles. `tdo` must return 0x1002AC05 LSB first; `tdo_oe`=1 throughout the shift.
- **IR capture and load:** shift IR with `tdi` pattern 5'h11 (`ChanIrBase`=0x10). The captured bits out must be 1,0,0,0,0. After UpdIR, `chan_select`=2'b10 and `ir_q`=5'h11.
- **BYPASS path:** load IR 5'h1F, then shift `tdi`=1,0,1,1 in ShDR. `tdo` must read 0 (captured bit) followed by 1,0,1,1, each delayed 2 cycles from its `tdi`.
- **TMS reset:** from ShIR, drive `tms`=1 for 5 cycles. The FSM must reach TLR, with `ir_q`=1 and `test_logic_reset`=1.
- **Asynchronous reset mid-shift:** pull `trst` low between edges in the middle of ShDR with channel 0 selected. `tdo`, `tdo_oe` and `chan_select` must go to 0 immediately, and `ir_q` must equal IDCODE.
- **Idle counter** (`IdleCntW`=4): hold RTI for 20 cycles. `idle_cnt` must step 1..15 and then hold at 15. It must read 0 in the first cycle of SelDR.
